// File: rtl/control_word_feeder_if.sv
// Word-input handshake for control_word_feeder.
// Valid/ready: the slave accepts a word on a rising edge where In_Valid && In_Ready; the
// master holds In_Word stable with In_Valid high until that edge, and In_Ready never depends on In_Valid.
interface control_word_feeder_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [39:0] In_Word;

  modport master (output In_Valid, output In_Word, input In_Ready);
  modport slave  (input In_Valid, input In_Word, output In_Ready);
endinterface

// File: rtl/control_word_feeder.sv
// FIFO-buffered control-word issuer for ALUSystem, metered by a run/halt state machine.
// Optional macro CWF_SINGLE_STEP_EN adds a Step input that gates each issue in RUN.
module control_word_feeder #(
  parameter int          DEPTH     = 4,
  parameter logic [39:0] IDLE_WORD = 40'h00_0000_0020,
  localparam int         AW        = $clog2(DEPTH),
  localparam int         LW        = AW + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  control_word_feeder_if.slave in_if,
  input  logic                Run,
  input  logic                Clear,
`ifdef CWF_SINGLE_STEP_EN
  input  logic                Step,
`endif
  output logic                Halted,
  output logic [15:0]         Issued_Count,
  output logic [LW-1:0]       Level,
  output logic [1:0]          Dbg_State,
  output logic                Operation,
  output logic [1:0]          RF_OutASel,
  output logic [1:0]          RF_OutBSel,
  output logic [1:0]          RF_FunSel,
  output logic [3:0]          RF_RSel,
  output logic [3:0]          RF_TSel,
  output logic [3:0]          ALU_FunSel,
  output logic [1:0]          ARF_OutASel,
  output logic [1:0]          ARF_OutBSel,
  output logic [1:0]          ARF_FunSel,
  output logic [3:0]          ARF_RSel,
  output logic                IR_LH,
  output logic                IR_Enable,
  output logic [1:0]          IR_Funsel,
  output logic                Mem_WR,
  output logic                Mem_CS,
  output logic [1:0]          MuxASel,
  output logic [1:0]          MuxBSel,
  output logic                MuxCSel
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [39:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     count_q, count_d;
  logic [39:0]     word_q, word_d;

  logic            full, empty, push, pop, step_ok;
  logic [39:0]     head_word;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign head_word = mem_q[rd_ptr_q];

`ifdef CWF_SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  // Push decision uses the registered full flag only, so a pop never opens a same-cycle push.
  assign push = in_if.In_Valid && !full && !Clear;
  assign pop  = (state_q == ST_RUN) && !empty && step_ok && !Clear;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    word_d   = IDLE_WORD;

    if (Clear) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (Run) state_d = ST_RUN;
        ST_RUN: begin
          // A halting word is still issued; halt wins over a simultaneous Run drop.
          if (pop && head_word[39]) state_d = ST_HALTED;
          else if (!Run)            state_d = ST_IDLE;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        word_d   = head_word;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      word_q   <= IDLE_WORD;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      word_q   <= word_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= in_if.In_Word;
  end

  assign in_if.In_Ready = !full;
  assign Halted         = (state_q == ST_HALTED);
  assign Issued_Count   = count_q;
  assign Level          = level_q;
  assign Dbg_State      = state_q;

  assign Operation   = word_q[39];
  assign RF_OutASel  = word_q[38:37];
  assign RF_OutBSel  = word_q[36:35];
  assign RF_FunSel   = word_q[34:33];
  assign RF_RSel     = word_q[32:29];
  assign RF_TSel     = word_q[28:25];
  assign ALU_FunSel  = word_q[24:21];
  assign ARF_OutASel = word_q[20:19];
  assign ARF_OutBSel = word_q[18:17];
  assign ARF_FunSel  = word_q[16:15];
  assign ARF_RSel    = word_q[14:11];
  assign IR_LH       = word_q[10];
  assign IR_Enable   = word_q[9];
  assign IR_Funsel   = word_q[8:7];
  assign Mem_WR      = word_q[6];
  assign Mem_CS      = word_q[5];
  assign MuxASel     = word_q[4:3];
  assign MuxBSel     = word_q[2:1];
  assign MuxCSel     = word_q[0];

endmodule

// File: tb/tb_control_word_feeder.sv
// Directed bench for control_word_feeder (DEPTH=4); the single-step section builds only with CWF_SINGLE_STEP_EN.
module tb_control_word_feeder;
  localparam int          DEPTH = 4;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [39:0] IDLE  = 40'h00_0000_0020;

  logic Clock = 1'b0;
  logic Reset, Run, Clear;
`ifdef CWF_SINGLE_STEP_EN
  logic Step;
`endif
  logic          Halted;
  logic [15:0]   Issued_Count;
  logic [LW-1:0] Level;
  logic [1:0]    Dbg_State;
  logic Operation, IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel;
  logic [1:0] RF_OutASel, RF_OutBSel, RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [1:0] IR_Funsel, MuxASel, MuxBSel;
  logic [3:0] RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;
  logic [39:0] out_word;

  control_word_feeder_if bus();

  control_word_feeder #(.DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
    .Clock(Clock), .Reset(Reset), .in_if(bus), .Run(Run), .Clear(Clear),
`ifdef CWF_SINGLE_STEP_EN
    .Step(Step),
`endif
    .Halted(Halted), .Issued_Count(Issued_Count), .Level(Level), .Dbg_State(Dbg_State),
    .Operation(Operation), .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
  );

  assign out_word = {Operation, RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
                     ALU_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH,
                     IR_Enable, IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

  // clock / reset
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];
  logic [39:0] fw [5];
  logic [39:0] hw [3];
  logic [39:0] w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_word(input logic [39:0] word);
    bus.In_Valid = 1'b1;
    bus.In_Word  = word;
    tick();
    bus.In_Valid = 1'b0;
  endtask

  initial begin
    fw[0] = 40'h00_1111_0001; fw[1] = 40'h12_2222_0002; fw[2] = 40'h34_3333_0004;
    fw[3] = 40'h56_4444_0008; fw[4] = 40'h78_5555_0010;
    hw[0] = 40'h0A_0000_0040; hw[1] = 40'h80_0000_0001; hw[2] = 40'h0C_0000_0080;

    Reset = 1'b0; Run = 1'b0; Clear = 1'b0;
    bus.In_Valid = 1'b0; bus.In_Word = '0;
`ifdef CWF_SINGLE_STEP_EN
    Step = 1'b0;
`endif
    #12;
    check("rst_out",   64'(out_word), 64'(IDLE));
    check("rst_level", 64'(Level), 64'd0);
    check("rst_ready", 64'(bus.In_Ready), 64'd1);
    check("rst_count", 64'(Issued_Count), 64'd0);
    check("rst_halt",  64'(Halted), 64'd0);

    tick(); Reset = 1'b1;
    tick(); tick();
    check("idle_out",   64'(out_word), 64'(IDLE));
    check("idle_state", 64'(Dbg_State), 64'd0);

    // fill to full with Run low, then a fifth word waits for a pop
    for (int i = 0; i < 4; i++) drive_word(fw[i]);
    check("full_level", 64'(Level), 64'd4);
    check("full_ready", 64'(bus.In_Ready), 64'd0);
    bus.In_Valid = 1'b1; bus.In_Word = fw[4];
    tick(); tick();
    check("full_hold_level", 64'(Level), 64'd4);
    check("full_hold_out",   64'(out_word), 64'(IDLE));
    Run = 1'b1;
    tick();
    check("run_state", 64'(Dbg_State), 64'd1);
    check("run_first_idle", 64'(out_word), 64'(IDLE));
    tick();
    check("drain0_out",   64'(out_word), 64'(fw[0]));
    check("drain0_level", 64'(Level), 64'd3);
    tick();
    bus.In_Valid = 1'b0;
    check("drain1_out",   64'(out_word), 64'(fw[1]));
    check("drain1_level", 64'(Level), 64'd3);
    for (int i = 2; i < 5; i++) begin
      tick();
      check("drain_out",   64'(out_word), 64'(fw[i]));
      check("drain_level", 64'(Level), 64'(4 - i));
    end
    tick();
    check("drain_end_out", 64'(out_word), 64'(IDLE));
    check("drain_count",   64'(Issued_Count), 64'd5);

    // clear while Run is held, then single-word latency
    Clear = 1'b1; tick(); Clear = 1'b0;
    check("clr_count", 64'(Issued_Count), 64'd0);
    check("clr_state", 64'(Dbg_State), 64'd0);
    tick();
    drive_word(40'h01_2345_6780);
    check("lat_k_level", 64'(Level), 64'd1);
    check("lat_k_out",   64'(out_word), 64'(IDLE));
    tick();
    check("lat_out",   64'(out_word), 64'h01_2345_6780);
    check("lat_rsel",  64'(RF_RSel), 64'h9);
    check("lat_count", 64'(Issued_Count), 64'd1);

    // halt on bit39
    Run = 1'b0; tick();
    for (int i = 0; i < 3; i++) drive_word(hw[i]);
    check("halt_q_level", 64'(Level), 64'd3);
    Run = 1'b1; tick();
    tick();
    check("halt_a_out", 64'(out_word), 64'(hw[0]));
    check("halt_a_h",   64'(Halted), 64'd0);
    tick();
    check("halt_b_out",   64'(out_word), 64'(hw[1]));
    check("halt_b_h",     64'(Halted), 64'd1);
    check("halt_b_level", 64'(Level), 64'd1);
    check("halt_b_count", 64'(Issued_Count), 64'd3);
    tick();
    check("halt_idle_out", 64'(out_word), 64'(IDLE));
    check("halt_c_kept",   64'(Level), 64'd1);
    Run = 1'b0; tick(); Run = 1'b1; tick();
    check("halt_ignore_run", 64'(Halted), 64'd1);
    Run = 1'b0;
    Clear = 1'b1; bus.In_Valid = 1'b1; bus.In_Word = 40'h11_1111_1111;
    tick();
    Clear = 1'b0; bus.In_Valid = 1'b0;
    check("halt_clr_level", 64'(Level), 64'd0);
    check("halt_clr_h",     64'(Halted), 64'd0);
    check("halt_clr_count", 64'(Issued_Count), 64'd0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive_word(fw[i]);
    check("pre_rst_level", 64'(Level), 64'd3);
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_level", 64'(Level), 64'd0);
    check("mid_rst_ready", 64'(bus.In_Ready), 64'd1);
    check("mid_rst_out",   64'(out_word), 64'(IDLE));
    tick(); Reset = 1'b1;
    tick();
    check("post_rst_out", 64'(out_word), 64'(IDLE));

    // wrap-around: 10 words, concurrent push/pop
    Run = 1'b1; tick();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        w = {1'b0, 39'(64'h13_5791_3579 * (i + 1))};
        check("wrap_ready", 64'(bus.In_Ready), 64'd1);
        bus.In_Valid = 1'b1; bus.In_Word = w;
        exp_q.push_back(w);
      end else begin
        bus.In_Valid = 1'b0;
      end
      tick();
      if (i >= 1) check("wrap_out", 64'(out_word), 64'(exp_q.pop_front()));
    end
    check("wrap_count", 64'(Issued_Count), 64'd10);
    check("wrap_level", 64'(Level), 64'd0);

`ifdef CWF_SINGLE_STEP_EN
    Run = 1'b0; tick();
    for (int i = 0; i < 3; i++) drive_word(fw[i]);
    Run = 1'b1; Step = 1'b0; tick();
    tick();
    check("step0_out",   64'(out_word), 64'(IDLE));
    check("step0_level", 64'(Level), 64'd3);
    Step = 1'b1; tick(); Step = 1'b0;
    check("step1_out", 64'(out_word), 64'(fw[0]));
    tick();
    check("step_gap_out", 64'(out_word), 64'(IDLE));
    Step = 1'b1; tick(); Step = 1'b0;
    check("step2_out", 64'(out_word), 64'(fw[1]));
    tick();
    check("step_level", 64'(Level), 64'd1);
    check("step_count", 64'(Issued_Count), 64'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
